// File: rtl/debug_pkg.sv
// Shared encodings for the debug/fetch sequencing path: states, command bytes, halt word.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PRERUN = 3'd2,
    ST_RUN    = 3'd3,
    ST_STEP   = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_NEXT = 8'h4E;
  localparam logic [7:0] CMD_EXIT = 8'h45;

  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a byte stream MSB-first into words; word_valid pulses the cycle after the last byte.
module byte_word_assembler #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_byte_valid,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_valid
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_BYTES - 1);

  logic [NB_IDX-1:0] idx_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_word       <= '0;
      idx_q        <= '0;
      o_word_valid <= 1'b0;
    end else begin
      o_word_valid <= 1'b0;
      if (i_clear) begin
        o_word <= '0;
        idx_q  <= '0;
      end else if (i_byte_valid) begin
        o_word <= {o_word[NB_DATA-NB_BYTE-1:0], i_byte};
        if (idx_q == LAST_IDX) begin
          idx_q        <= '0;
          o_word_valid <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fetch_run_controller.sv
// Debug-flow sequencer: loads instruction memory from the RX byte stream, then runs
// the fetch pipeline continuously or one step at a time until HALT.
module fetch_run_controller
  import debug_pkg::*;
#(
  parameter int NB_DATA        = 32,
  parameter int N_MEM_ADDRESS  = 128,
  parameter int NB_MEM_ADDRESS = $clog2(N_MEM_ADDRESS) + 2,
  parameter int NB_COUNT       = 32,
  parameter logic [NB_DATA-1:0] HALT_CODE = NB_DATA'(HALT_WORD)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_valid,
  input  logic                      i_halt,
  output logic                      o_mem_w_en,
  output logic [NB_MEM_ADDRESS-1:0] o_mem_w_addr,
  output logic [NB_DATA-1:0]        o_mem_w_data,
  output logic                      o_pipe_en,
  output logic                      o_pipe_reset,
  output logic [NB_COUNT-1:0]       o_cycle_count,
  output logic [2:0]                o_state,
  output logic                      o_done,
  output logic                      o_load_err
);

  localparam logic [NB_MEM_ADDRESS-1:0] ADDR_LAST = NB_MEM_ADDRESS'((N_MEM_ADDRESS - 1) * 4);
  localparam logic [NB_MEM_ADDRESS-1:0] ADDR_STEP = NB_MEM_ADDRESS'(4);

  state_t state_q, state_d, target_q, target_d;
  logic [NB_MEM_ADDRESS-1:0] addr_q;
  logic [NB_COUNT-1:0]       count_q;
  logic load_err_q, step_q, done_q;
  logic clear_load, set_err, addr_inc, step_d;
  logic word_valid;
  logic [NB_DATA-1:0] word;

  byte_word_assembler #(.NB_DATA(NB_DATA), .NB_BYTE(8)) u_asm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (clear_load),
    .i_byte_valid (i_rx_valid && (state_q == ST_LOAD)),
    .i_byte       (i_rx_data),
    .o_word       (word),
    .o_word_valid (word_valid)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    clear_load = 1'b0;
    set_err    = 1'b0;
    addr_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin state_d = ST_LOAD; clear_load = 1'b1; end
            CMD_CONT: begin state_d = ST_PRERUN; target_d = ST_RUN; end
            CMD_STEP: begin state_d = ST_PRERUN; target_d = ST_STEP; end
            default: ;
          endcase
        end
      end
      ST_LOAD: begin
        if (word_valid) begin
          if (word == HALT_CODE) begin
            state_d = ST_IDLE;
          end else if (addr_q == ADDR_LAST) begin
            set_err = 1'b1;
            state_d = ST_IDLE;
          end else begin
            addr_inc = 1'b1;
          end
        end
      end
      ST_PRERUN: state_d = target_q;
      ST_RUN, ST_STEP: begin
        // halt from the pipeline outranks any command byte in the same cycle
        if (i_halt) state_d = ST_HALTED;
        else if (i_rx_valid && (i_rx_data == CMD_EXIT)) state_d = ST_IDLE;
      end
      ST_HALTED: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_EXIT: state_d = ST_IDLE;
            CMD_CONT: begin state_d = ST_PRERUN; target_d = ST_RUN; end
            CMD_STEP: begin state_d = ST_PRERUN; target_d = ST_STEP; end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign step_d = (state_q == ST_STEP) && (state_d == ST_STEP) &&
                  i_rx_valid && (i_rx_data == CMD_NEXT);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      target_q   <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      load_err_q <= 1'b0;
      step_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      step_q   <= step_d;
      done_q   <= (state_d == ST_HALTED) && (state_q != ST_HALTED);
      if (clear_load) begin
        addr_q     <= '0;
        load_err_q <= 1'b0;
      end else begin
        if (addr_inc) addr_q <= addr_q + ADDR_STEP;
        if (set_err)  load_err_q <= 1'b1;
      end
      if (state_q == ST_PRERUN) count_q <= '0;
      else if (o_pipe_en && (count_q != '1)) count_q <= count_q + 1'b1;
    end
  end

  assign o_mem_w_en    = (state_q == ST_LOAD) && word_valid;
  assign o_mem_w_addr  = addr_q;
  assign o_mem_w_data  = word;
  assign o_pipe_en     = (state_q == ST_RUN) || ((state_q == ST_STEP) && step_q);
  assign o_pipe_reset  = (state_q == ST_PRERUN);
  assign o_cycle_count = count_q;
  assign o_state       = state_q;
  assign o_done        = done_q;
  assign o_load_err    = load_err_q;

endmodule

// File: tb/tb_fetch_run_controller.sv
// Self-checking bench for fetch_run_controller: load scoreboard, run/step sequences, resets.
module tb_fetch_run_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       halt = 1'b0;

  logic        w_en, pipe_en, pipe_reset, done, load_err;
  logic [8:0]  w_addr;
  logic [31:0] w_data, cycle_count;
  logic [2:0]  state;

  logic        s_w_en, s_pipe_en, s_pipe_reset, s_done, s_load_err;
  logic [3:0]  s_w_addr;
  logic [31:0] s_w_data, s_cycle_count;
  logic [2:0]  s_state;

  int checks = 0;
  int failures = 0;

  logic [40:0] exp_q[$], got_q[$], exp_s_q[$], got_s_q[$];

  always #5 clk = ~clk;

  fetch_run_controller dut (
    .i_clk(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_halt(halt),
    .o_mem_w_en(w_en), .o_mem_w_addr(w_addr), .o_mem_w_data(w_data), .o_pipe_en(pipe_en),
    .o_pipe_reset(pipe_reset), .o_cycle_count(cycle_count), .o_state(state), .o_done(done),
    .o_load_err(load_err)
  );

  fetch_run_controller #(.N_MEM_ADDRESS(4)) dut_small (
    .i_clk(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_halt(halt),
    .o_mem_w_en(s_w_en), .o_mem_w_addr(s_w_addr), .o_mem_w_data(s_w_data), .o_pipe_en(s_pipe_en),
    .o_pipe_reset(s_pipe_reset), .o_cycle_count(s_cycle_count), .o_state(s_state), .o_done(s_done),
    .o_load_err(s_load_err)
  );

  // capture every write cycle; a stretched pulse shows up as an extra entry
  always @(negedge clk) begin
    if (w_en)   got_q.push_back({w_addr, w_data});
    if (s_w_en) got_s_q.push_back({5'd0, s_w_addr, s_w_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    logic [40:0] e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        check({name, "_missing"}, 64'(1), 64'(0));
      end else begin
        g = got_q.pop_front();
        check({name, "_write"}, 64'(g), 64'(e));
      end
    end
    check({name, "_extra"}, 64'(got_q.size()), 64'(0));
    got_q.delete();
  endtask

  typedef struct {
    logic [31:0] word;
    logic [8:0]  exp_addr;
  } load_vec_t;

  load_vec_t load_tab[4];
  int n_en;
  int n_pulse;
  bit reached;

  initial begin
    load_tab[0] = '{32'h2001_0005, 9'd0};
    load_tab[1] = '{32'h4C45_4E53, 9'd4};   // command bytes are plain data in LOAD
    load_tab[2] = '{32'h8C22_0004, 9'd8};
    load_tab[3] = '{32'hFC00_0000, 9'd12};

    // reset values while reset is held
    #12;
    check("rst_state", 64'(state), 64'(0));
    check("rst_outputs", 64'({w_en, pipe_en, pipe_reset, done, load_err}), 64'(0));
    check("rst_count", 64'(cycle_count), 64'(0));
    check("rst_mem_bus", 64'({w_addr, w_data}), 64'(0));
    #10 rst_n = 1'b1;
    idle_cycles(2);

    // bytes that are not commands in IDLE are ignored
    send_byte(CMD_NEXT_B());
    send_byte(8'h45);
    @(negedge clk);
    check("idle_ignore", 64'(state), 64'(0));

    // table-driven load; scoreboard expectations queued as words are sent
    send_byte(8'h4C);
    @(negedge clk);
    check("load_enter", 64'(state), 64'(1));
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({load_tab[i].exp_addr, load_tab[i].word});
      send_word(load_tab[i].word);
    end
    idle_cycles(3);
    drain("load");
    @(negedge clk);
    check("load_end_state", 64'(state), 64'(0));
    check("load_end_err", 64'(load_err), 64'(0));
    check("load_no_wen", 64'(w_en), 64'(0));

    // continuous run
    send_byte(8'h43);
    @(negedge clk);
    check("prerun_state", 64'(state), 64'(2));
    check("prerun_outs", 64'({pipe_reset, pipe_en}), 64'(2'b10));
    check("prerun_count", 64'(cycle_count), 64'(0));
    n_en = 0;
    reached = 1'b0;
    for (int c = 0; c < 50 && !reached; c++) begin
      @(negedge clk);
      if (pipe_en) begin
        n_en++;
        if (n_en == 10) begin
          halt = 1'b1;
          reached = 1'b1;
        end
      end
    end
    check("run_reach10", 64'(reached), 64'(1));
    @(posedge clk); #1;
    halt = 1'b0;
    @(negedge clk);
    check("halt_state", 64'(state), 64'(5));
    check("halt_done", 64'(done), 64'(1));
    check("halt_pipe_en", 64'(pipe_en), 64'(0));
    check("halt_count", 64'(cycle_count), 64'(n_en));
    check("halt_count10", 64'(cycle_count), 64'(10));
    @(negedge clk);
    check("done_once", 64'(done), 64'(0));
    idle_cycles(3);
    check("halt_count_hold", 64'(cycle_count), 64'(10));

    // restart from HALTED into step mode
    send_byte(8'h53);
    @(negedge clk);
    check("step_prerun", 64'({state, pipe_reset}), 64'({3'd2, 1'b1}));
    @(negedge clk);
    check("step_state", 64'(state), 64'(4));
    check("step_count_clr", 64'(cycle_count), 64'(0));
    check("step_idle_en", 64'(pipe_en), 64'(0));
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h4E);
      @(negedge clk);
      check("step_pulse", 64'(pipe_en), 64'(1));
      n_pulse = 0;
      for (int c = 0; c < 19; c++) begin
        @(negedge clk);
        if (pipe_en) n_pulse++;
      end
      check("step_single", 64'(n_pulse), 64'(0));
    end
    check("step_count", 64'(cycle_count), 64'(3));
    send_byte(8'h45);
    @(negedge clk);
    check("step_exit", 64'(state), 64'(0));

    // halt and exit in the same cycle: halt wins
    send_byte(8'h53);
    idle_cycles(3);
    @(posedge clk); #1;
    rx_data = 8'h45; rx_valid = 1'b1; halt = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; halt = 1'b0;
    @(negedge clk);
    check("collide_state", 64'(state), 64'(5));
    check("collide_done", 64'(done), 64'(1));

    // exit from RUN, then async reset mid-RUN
    send_byte(8'h43);
    idle_cycles(6);
    send_byte(8'h45);
    @(negedge clk);
    check("run_exit", 64'({state, pipe_en}), 64'({3'd0, 1'b0}));
    send_byte(8'h43);
    idle_cycles(8);
    @(negedge clk);
    check("run_counting", 64'(cycle_count > 0), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("areset_state", 64'(state), 64'(0));
    check("areset_count", 64'(cycle_count), 64'(0));
    check("areset_pipe", 64'({pipe_en, pipe_reset, done}), 64'(0));
    #10 rst_n = 1'b1;
    idle_cycles(2);

    // overflow on the 4-word instance; the 128-word instance keeps loading
    got_q.delete();
    got_s_q.delete();
    send_byte(8'h4C);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_s_q.push_back({5'd0, 4'(i * 4), 32'h1111_0001 + 32'(i)});
      send_word(32'h1111_0001 + 32'(i));
    end
    idle_cycles(3);
    while (exp_s_q.size() > 0) begin
      logic [40:0] e;
      e = exp_s_q.pop_front();
      if (got_s_q.size() == 0) check("ovf_missing", 64'(1), 64'(0));
      else check("ovf_write", 64'(got_s_q.pop_front()), 64'(e));
    end
    check("ovf_no_5th", 64'(got_s_q.size()), 64'(0));
    @(negedge clk);
    check("ovf_err", 64'(s_load_err), 64'(1));
    check("ovf_state", 64'(s_state), 64'(0));
    check("big_still_load", 64'({state, load_err}), 64'({3'd1, 1'b0}));
    check("big_writes", 64'(got_q.size()), 64'(5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [7:0] CMD_NEXT_B();
    return 8'h4E;
  endfunction

endmodule

// File: doc/fetch_run_controller.md
Name: fetch_run_controller

Overview:
- Sequences the instruction-fetch datapath for the debug flow. Loads a program into instruction memory from a byte stream (UART receiver side), then releases the pipeline in continuous or single-step mode.
- Owns the memory write port during load, the pipeline enable (stall) and the pipeline's synchronous reset. Freezes on HALT.
- Sits between the UART RX/debug unit and the fetch stage; exports status for the TX/debug path.

Parameters:
- NB_DATA, 32, instruction word width.
- N_MEM_ADDRESS, 128, instruction memory depth in words.
- NB_MEM_ADDRESS, $clog2(N_MEM_ADDRESS)+2, byte-address width of instruction memory.
- NB_COUNT, 32, cycle counter width.
- HALT_CODE, 32'hFC00_0000, instruction word that ends a load and that the pipeline reports as halt.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid.
- i_halt  in  1  pipeline retired HALT_CODE.
- o_mem_w_en  out  1  instruction memory write enable.
- o_mem_w_addr  out  NB_MEM_ADDRESS  byte write address, word aligned.
- o_mem_w_data  out  NB_DATA  assembled word.
- o_pipe_en  out  1  1 = pipeline advances; 0 = stall all stages.
- o_pipe_reset  out  1  synchronous reset pulse to pipeline/PC.
- o_cycle_count  out  NB_COUNT  pipeline cycles executed since last start.
- o_state  out  3  current state encoding.
- o_done  out  1  one-cycle pulse on entering HALTED.
- o_load_err  out  1  sticky: load overflowed memory.

Behaviour:
- Reset (async, i_reset=0): state IDLE; all outputs 0; byte index 0; word address 0; count 0.
- Commands are accepted only when i_rx_valid=1. Bytes not valid in the current state are ignored.
- Command bytes: 'L'=0x4C load, 'C'=0x43 continuous, 'S'=0x53 step mode, 'N'=0x4E next step, 'E'=0x45 exit to IDLE.
- IDLE:
  - 'L' -> LOAD; clears address, byte index and o_load_err.
  - 'C' -> PRERUN with target RUN.
  - 'S' -> PRERUN with target STEP.
  - Other bytes are ignored.
- LOAD:
  - Bytes are assembled MSB-first into a shift register.
  - On the 4th byte, the next cycle drives o_mem_w_en=1 for exactly 1 cycle, with the word and the current address. The address then increments by 4.
  - If the written word == HALT_CODE -> IDLE, after the write.
  - If the address would exceed (N_MEM_ADDRESS-1)*4 after a non-halt write -> set o_load_err, go to IDLE.
  - Command bytes have no special meaning in LOAD; all bytes are data.
- PRERUN: exactly 1 cycle. o_pipe_reset=1, o_pipe_en=0, o_cycle_count cleared. Next state is the stored target.
- RUN:
  - o_pipe_en=1 every cycle; count +1 per enabled cycle.
  - i_halt=1 -> HALTED; o_pipe_en=0 from the next cycle.
  - 'E' -> IDLE.
- STEP:
  - o_pipe_en=0 by default. 'N' -> o_pipe_en=1 for exactly one cycle, the cycle after the strobe; count +1.
  - i_halt seen in the stepped cycle -> HALTED.
  - 'E' -> IDLE.
- HALTED:
  - o_done=1 on the first cycle only; o_pipe_en=0; count holds.
  - 'E' -> IDLE. 'C'/'S' -> PRERUN (restart).
- Simultaneous events: i_halt wins over 'N' or 'E' in the same cycle.
- Counter saturates at all-ones; it never wraps.
- o_mem_w_en is never asserted outside LOAD.
- o_pipe_en is never asserted in IDLE, LOAD, PRERUN or HALTED.
- Reset mid-LOAD or mid-RUN: immediate return to reset values. Memory contents are untouched.

Decomposition:
- Shared package `debug_pkg`: state encodings (IDLE=0, LOAD=1, PRERUN=2, RUN=3, STEP=4, HALTED=5), command byte constants, HALT_CODE.
- One sub-module: `byte_word_assembler`. It does the 4-byte MSB-first shift, byte index counter and word_valid pulse, with a clear input.

Test Plan:
- Reset → load: after reset, send 'L', then 0x20,0x01,0x00,0x05, then FC,00,00,00 → two writes: addr 0 data 0x2001_0005, then addr 4 data 0xFC00_0000. Then state IDLE and o_load_err=0.
- Load overflow: with N_MEM_ADDRESS=4, send 'L' plus 5 non-halt words → 4 writes at 0,4,8,12; o_load_err=1; state IDLE; 5th word is not written.
- Continuous run: send 'C' → one-cycle o_pipe_reset, then o_pipe_en=1. Assert i_halt after 10 enabled cycles → o_cycle_count=10, o_done pulses once, o_pipe_en=0.
- Step mode: send 'S', then 3 'N' strobes spaced 20 cycles → exactly 3 single-cycle o_pipe_en pulses; count=3. Then 'E' → IDLE.
- Collision: in STEP, i_halt in the same cycle as an 'E' strobe → state HALTED (not IDLE); o_done=1.
- Async reset mid-RUN: drop i_reset between clock edges → outputs clear immediately without a clock edge; state IDLE; count 0.
